// File: rtl/mem_port_arbiter_if.sv
// Bundle of IF requester, MEM requester and RAM-side signals shared by the
// unified-memory arbiter; the arbiter sits on the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic [DATA_W-1:0] ifData;
  logic              ifValid;

  // MEM-stage requester
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;
  logic              memValid;

  // Single-ported RAM
  logic              ramReq;
  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWData;
  logic [DATA_W-1:0] ramRData;
  logic              ramAck;

  // Pipeline hazard hooks
  logic              stallIf;
  logic              stallMem;

  modport slave (
    input  ifReq, ifAddr, memReq, memWe, memAddr, memWData, ramRData, ramAck,
    output ifData, ifValid, memRData, memValid,
    output ramReq, ramWe, ramAddr, ramWData, stallIf, stallMem
  );

  modport master (
    output ifReq, ifAddr, memReq, memWe, memAddr, memWData, ramRData, ramAck,
    input  ifData, ifValid, memRData, memValid,
    input  ramReq, ramWe, ramAddr, ramWData, stallIf, stallMem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified RAM between instruction fetch and the
// MEM stage: MEM wins by age, a starvation counter bounds how long IF waits.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM,
    DONE
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            r_state;
  logic [3:0]        r_starve_cnt;
  logic              r_ram_req;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_valid;
  logic              r_mem_valid;

  logic w_if_forced;
  logic w_grant_mem;
  logic w_grant_if;

  // IF is forced through once MEM has won STARVE_MAX times in a row over it.
  assign w_if_forced = bus.ifReq && (r_starve_cnt == STARVE_LIM);
  assign w_grant_mem = bus.memReq && !w_if_forced;
  assign w_grant_if  = bus.ifReq && !w_grant_mem;

  // NOTE: asynchronous reset so ramReq drops the instant reset rises, even
  // mid-access; all state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
      r_ram_req    <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_if_data    <= '0;
      r_mem_rdata  <= '0;
      r_if_valid   <= 1'b0;
      r_mem_valid  <= 1'b0;
    end else begin
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_grant_mem) begin
            r_state     <= BUSY_MEM;
            r_ram_req   <= 1'b1;
            r_ram_we    <= bus.memWe;
            r_ram_addr  <= bus.memAddr;
            r_ram_wdata <= bus.memWData;
            if (bus.ifReq && (r_starve_cnt != STARVE_LIM)) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end else if (w_grant_if) begin
            r_state      <= BUSY_IF;
            r_ram_req    <= 1'b1;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= bus.ifAddr;
            r_starve_cnt <= 4'd0;
          end
        end

        BUSY_IF: begin
          if (bus.ramAck) begin
            r_state    <= DONE;
            r_ram_req  <= 1'b0;
            r_if_data  <= bus.ramRData;
            r_if_valid <= 1'b1;
          end
        end

        BUSY_MEM: begin
          if (bus.ramAck) begin
            r_state     <= DONE;
            r_ram_req   <= 1'b0;
            r_mem_valid <= 1'b1;
            if (!r_ram_we) begin
              r_mem_rdata <= bus.ramRData;
            end
          end
        end

        // One dead cycle so a requester that has not yet retired is never re-granted.
        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ramReq   = r_ram_req;
  assign bus.ramWe    = r_ram_we;
  assign bus.ramAddr  = r_ram_addr;
  assign bus.ramWData = r_ram_wdata;
  assign bus.ifData   = r_if_data;
  assign bus.ifValid  = r_if_valid;
  assign bus.memRData = r_mem_rdata;
  assign bus.memValid = r_mem_valid;

  // Combinational so the pipeline advances on the very edge that ends the valid cycle.
  assign bus.stallIf  = bus.ifReq && !r_if_valid;
  assign bus.stallMem = bus.memReq && !r_mem_valid;

  a_single_valid: assert property (
    @(posedge clk) disable iff (reset) !(r_if_valid && r_mem_valid)
  );

  a_valid_only_in_done: assert property (
    @(posedge clk) disable iff (reset) (r_if_valid || r_mem_valid) |-> (r_state == DONE)
  );

  a_req_matches_busy: assert property (
    @(posedge clk) disable iff (reset)
      r_ram_req == ((r_state == BUSY_IF) || (r_state == BUSY_MEM))
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch (IF) requester and the MEM-stage data requester.
- Sequences each access through a request/acknowledge handshake with the RAM.
- Drives stall outputs that the pipeline hazard logic ORs into its PC, IF and control enables.
- MEM has priority because it is the older instruction; a starvation counter guarantees IF forward progress.

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM port.
- DATA_W, 32, data width.
- STARVE_MAX, 3, maximum consecutive MEM grants issued while IF is waiting before IF is forced to win; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ifReq  input  1  IF read request; held stable until ifValid.
- ifAddr  input  ADDR_W  IF read address.
- ifData  output  DATA_W  IF read data; valid when ifValid=1, holds last value otherwise.
- ifValid  output  1  one-cycle pulse: IF access complete.
- memReq  input  1  MEM-stage request; held stable until memValid.
- memWe  input  1  1=write, 0=read.
- memAddr  input  ADDR_W  MEM-stage address.
- memWData  input  DATA_W  MEM-stage write data.
- memRData  output  DATA_W  MEM-stage read data; updated only on reads.
- memValid  output  1  one-cycle pulse: MEM access complete.
- ramReq  output  1  RAM request; held until ramAck.
- ramWe  output  1  RAM write enable.
- ramAddr  output  ADDR_W  RAM address, latched at grant.
- ramWData  output  DATA_W  RAM write data, latched at grant.
- ramRData  input  DATA_W  RAM read data; sampled when ramAck=1.
- ramAck  input  1  RAM completion, one or more cycles after ramReq.
- stallIf  output  1  combinational: ifReq & ~ifValid.
- stallMem  output  1  combinational: memReq & ~memValid.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; starveCnt=0.
  - ramReq, ramWe, ifValid, memValid = 0.
  - ramAddr, ramWData, ifData, memRData = 0.
- FSM states: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE arbitration, evaluated at the clock edge:
  - memReq & ~(ifReq & starveCnt==STARVE_MAX) -> BUSY_MEM.
    - Latch memAddr, memWData, memWe.
    - If ifReq=1: starveCnt+1, saturating at STARVE_MAX.
  - Else if ifReq -> BUSY_IF.
    - Latch ifAddr; ramWe=0; starveCnt=0.
  - Else stay in IDLE. starveCnt is unchanged when ifReq=0.
- BUSY_x:
  - ramReq=1 and RAM outputs stay stable.
  - On ramAck=1:
    - ramReq falls at the next edge; go to DONE.
    - Pulse xValid in DONE.
    - For a read, capture ramRData into ifData or memRData.
    - For a MEM write, memRData is unchanged.
- DONE: exactly one cycle with the valid pulse, no grant, then IDLE.
  - This prevents re-granting a request the requester has not yet retired.
- Latency:
  - Request seen in IDLE at cycle c; ramReq asserted from c+1.
  - Ack at cycle a ≥ c+1 -> valid at a+1.
  - Earliest next grant is decided at a+2.
  - Minimum 3 cycles per access, 2-cycle issue-to-valid.
- ramAck while in IDLE or DONE is ignored.
- Only one access is outstanding at a time.
- Requests that deassert during BUSY do not abort the RAM access; the valid pulse still occurs.
- reset mid-BUSY: ramReq drops asynchronously, and an ack arriving after reset is ignored.
- stallIf and stallMem have no registered delay. They are 0 in the valid cycle, which lets the pipeline advance on that edge.

Test Plan:
- IF only: ifReq=1, ifAddr=0x40, ack 1 cycle after ramReq, ramRData=0x2402000A.
  - Required: ramAddr=0x40 and ramWe=0.
  - Required: ifValid pulses once with ifData=0x2402000A.
  - Required: stallIf=1 until that cycle.
- Simultaneous requests: ifReq & memReq (read 0x100) both high.
  - Required: MEM is granted first.
  - Required: IF is granted two cycles after memValid.
  - Required: starveCnt=1 and then 0.
- Starvation, STARVE_MAX=3: ifReq held, memReq held through repeated MEM writes.
  - Required: exactly 3 MEM grants, then an IF grant, then MEM resumes.
  - Required: memRData is unchanged by the writes.
- Slow RAM: ramAck delayed 5 cycles; memReq deasserted in cycle 2 of BUSY.
  - Required: ramReq and ramAddr are stable for all 5 cycles.
  - Required: memValid still pulses once.
  - Required: a spurious ramAck in IDLE causes no valid pulse.
- Reset: reset during BUSY_IF.
  - Required: ramReq=0 immediately.
  - Required: a later ramAck produces no ifValid.
  - Required: after release, a fresh ifReq completes normally.
